vga_fb_arbiter: RTL and testbench

Frame-buffer arbiter and sequencer sitting between the VGA timing generator and a single-port synchronous pixel RAM (160x120 cells, 3-bit RGB, each cell drawn as a 4x4 block on the 640x480 raster). It schedules display fetches at fixed raster slots and shares the remaining RAM cycles between a clear engine and an external write requester. It registers the fetched pixel to drive `rgb` in step with the raster.

---
 rtl/vga_fb_arbiter_if.sv | 31 +++
 rtl/vga_fb_arbiter.sv | 115 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Raster, writer, clear-engine and pixel-RAM signals around vga_fb_arbiter.
// The arbiter uses the slave modport; the requester/RAM/timing side uses master.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;
    logic              wr_ack;
    logic              clr_start;
    logic [2:0]        clr_color;
    logic              clr_busy;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [2:0]        ram_wdata;
    logic [2:0]        ram_rdata;
    logic [2:0]        rgb;

    modport slave (
        input  pixel_x, pixel_y, wr_req, wr_addr, wr_data, clr_start, clr_color, ram_rdata,
        output wr_ack, clr_busy, ram_en, ram_we, ram_addr, ram_wdata, rgb
    );

    modport master (
        output pixel_x, pixel_y, wr_req, wr_addr, wr_data, clr_start, clr_color, ram_rdata,
        input  wr_ack, clr_busy, ram_en, ram_we, ram_addr, ram_wdata, rgb
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Pixel-RAM arbiter: display fetch slots > clear engine > external writer, one access per cycle.
// Define VGA_ARB_VBLANK_WR_EN to restrict clear/writer grants to vertical blanking.
module vga_fb_arbiter #(
    parameter int ADDR_W = 15,
    parameter int FB_W   = 160,
    parameter int FB_H   = 120
) (
    input  logic clk,
    input  logic reset,
    vga_fb_arbiter_if.slave bus
);
    localparam int CELLS = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] sweep;
    logic [2:0]        color;
    logic              busy;
    logic [2:0]        pix_hold;
    logic [2:0]        rgb_q;

    logic [9:0]        dx, dy;
    logic [ADDR_W-1:0] row_a, col_a, disp_addr;
    logic              y_act, slot, cap, win_next, grant_ok, clr_go, wr_go, wr_in_range;

    assign dx = bus.pixel_x - 10'd142;
    assign dy = bus.pixel_y - 10'd35;

    assign y_act    = (bus.pixel_y >= 10'd35) && (bus.pixel_y <= 10'd514);
    assign slot     = y_act && (bus.pixel_x >= 10'd142) && (bus.pixel_x <= 10'd778) && (dx[1:0] == 2'd0);
    assign cap      = y_act && (bus.pixel_x >= 10'd143) && (bus.pixel_x <= 10'd779) && (dx[1:0] == 2'd1);
    // rgb is loaded one cycle ahead, so the window is tested against the next pixel.
    assign win_next = y_act && (bus.pixel_x >= 10'd143) && (bus.pixel_x <= 10'd782);

`ifdef VGA_ARB_VBLANK_WR_EN
    assign grant_ok = !slot && !y_act;
`else
    assign grant_ok = !slot;
`endif

    // row*160 as two shifts
    assign row_a     = ADDR_W'(dy >> 2);
    assign col_a     = ADDR_W'(dx >> 2);
    assign disp_addr = (row_a << 7) + (row_a << 5) + col_a;

    assign clr_go      = (state == CLEAR) && grant_ok;
    assign wr_go       = (state == IDLE) && grant_ok && bus.wr_req;
    assign wr_in_range = bus.wr_addr < ADDR_W'(CELLS);

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.wr_ack    = 1'b0;
        if (!reset) begin
            if (slot) begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = disp_addr;
            end else if (clr_go) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = sweep;
                bus.ram_wdata = color;
            end else if (wr_go) begin
                bus.wr_ack = 1'b1;
                if (wr_in_range) begin
                    bus.ram_en    = 1'b1;
                    bus.ram_we    = 1'b1;
                    bus.ram_addr  = bus.wr_addr;
                    bus.ram_wdata = bus.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sweep    <= '0;
            color    <= '0;
            busy     <= 1'b0;
            pix_hold <= '0;
            rgb_q    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.clr_start) begin
                    color <= bus.clr_color;
                    sweep <= '0;
                    busy  <= 1'b1;
                    state <= CLEAR;
                end
                CLEAR: if (clr_go) begin
                    if (sweep == LAST) begin
                        sweep <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (cap)
                pix_hold <= bus.ram_rdata;
            rgb_q <= win_next ? (cap ? bus.ram_rdata : pix_hold) : 3'd0;
        end
    end

    assign bus.clr_busy = busy;
    assign bus.rgb      = rgb_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: vector table for per-cycle arbitration plus
// hand-written sequences for reset, display latency, writer latency and clear.
module tb_vga_fb_arbiter;
    localparam int AW    = 15;
    localparam int CELLS = 19200;
`ifdef VGA_ARB_VBLANK_WR_EN
    localparam int NV = 0;
`else
    localparam int NV = 1;
`endif

    typedef struct {
        int x; int y; int req; int addr; int data;
        int exp_en; int exp_we; int exp_addr; int exp_ack;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic zap;
    logic [2:0] mem [CELLS];
    int n_chk = 0;
    int n_err = 0;

    vga_fb_arbiter_if #(.ADDR_W(AW)) bus ();
    vga_fb_arbiter #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Synchronous single-port RAM model.
    always @(posedge clk) begin
        if (zap) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= 3'd0;
            bus.ram_rdata <= 3'd0;
        end else if (bus.ram_en && int'(bus.ram_addr) < CELLS) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int x, input int y);
        bus.pixel_x = 10'(x);
        bus.pixel_y = 10'(y);
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_rgb(input int mode, input int x, input int y);
        if (x < 144 || x > 783) return 0;
        case (mode)
            1:       return (y >= 39 && y <= 42 && x >= 148 && x <= 151) ? 7 : 0;
            2:       return (y == 35 && x >= 164 && x <= 167) ? 6 : 3;
            default: return 0;
        endcase
    endfunction

    task automatic row_check(input string nm, input int mode, input int y, input int x0, input int x1);
        int bad = 0;
        for (int x = x0 - 2; x <= x1; x++) begin
            cyc(x, y);
            if (x >= x0 && int'(bus.rgb) != exp_rgb(mode, x, y)) begin
                if (bad == 0) $display("  row y=%0d first bad x=%0d rgb=%0d", y, x, bus.rgb);
                bad++;
            end
            adv();
        end
        chk(nm, bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[13];
        int bad, busy_cyc, clr_wr, early_ack, done;

        vt[0]  = '{142, 35, 0,   0, 0, 1,  0,     0, 0};
        vt[1]  = '{146, 35, 0,   0, 0, 1,  0,     1, 0};
        vt[2]  = '{778, 514, 0,  0, 0, 1,  0, 19199, 0};
        vt[3]  = '{150, 100, 0,  0, 0, 1,  0,  2562, 0};
        vt[4]  = '{141, 35, 0,   0, 0, 0,  0,     0, 0};
        vt[5]  = '{782, 514, 0,  0, 0, 0,  0,     0, 0};
        vt[6]  = '{142, 34, 0,   0, 0, 0,  0,     0, 0};
        vt[7]  = '{142, 515, 0,  0, 0, 0,  0,     0, 0};
        vt[8]  = '{142, 40, 1, 300, 4, 1,  0,   160, 0};
        vt[9]  = '{143, 40, 1, 300, 4, NV, NV,  300, NV};
        vt[10] = '{0, 0, 1, 19200, 1, 0,  0,     0, 1};
        vt[11] = '{10, 520, 1,  77, 6, 1,  1,    77, 1};
        vt[12] = '{146, 39, 0,   0, 0, 1,  0,   161, 0};

        reset = 1'b1; zap = 1'b1;
        bus.wr_req = 1'b1; bus.wr_addr = 15'd10; bus.wr_data = 3'd3;
        bus.clr_start = 1'b0; bus.clr_color = 3'd0;
        cyc(142, 40);
        chk("reset_outputs", {bus.rgb, bus.wr_ack, bus.clr_busy, bus.ram_en, bus.ram_we,
                              bus.ram_addr, bus.ram_wdata}, 0);
        adv();
        zap = 1'b0; reset = 1'b0; bus.wr_req = 1'b0;

        // Reset in the middle of a clear.
        bus.clr_start = 1'b1; bus.clr_color = 3'd3;
        cyc(0, 0); adv();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 20; i++) begin cyc(0, 0); adv(); end
        bus.wr_req = 1'b1; bus.wr_addr = 15'd9; bus.wr_data = 3'd1;
        cyc(0, 0);
        chk("clr_busy_running", bus.clr_busy, 1);
        reset = 1'b1; #1;
        chk("reset_midclear", {bus.clr_busy, bus.ram_en, bus.ram_we, bus.wr_ack}, 0);
        adv();
        reset = 1'b0; bus.wr_req = 1'b0;
        cyc(0, 0);
        chk("busy_after_reset", bus.clr_busy, 0);
        zap = 1'b1; adv(); zap = 1'b0;
        row_check("rgb_zero_y35", 0, 35, 140, 790);
        row_check("rgb_zero_y514", 0, 514, 140, 790);

        // Per-cycle arbitration table.
        for (int i = 0; i < 13; i++) begin
            bus.wr_req = vt[i].req[0]; bus.wr_addr = 15'(vt[i].addr); bus.wr_data = 3'(vt[i].data);
            cyc(vt[i].x, vt[i].y);
            chk($sformatf("v%0d_en", i), bus.ram_en, vt[i].exp_en);
            chk($sformatf("v%0d_we", i), bus.ram_we, vt[i].exp_we);
            chk($sformatf("v%0d_ack", i), bus.wr_ack, vt[i].exp_ack);
            if (vt[i].exp_en != 0) chk($sformatf("v%0d_addr", i), bus.ram_addr, vt[i].exp_addr);
            if (vt[i].exp_we != 0) chk($sformatf("v%0d_wdata", i), bus.ram_wdata, vt[i].data);
            adv();
        end
        bus.wr_req = 1'b0;
        zap = 1'b1; adv(); zap = 1'b0;

        // Preload cells 0 and 1 through the writer, then watch row 35.
        bus.wr_req = 1'b1; bus.wr_addr = 15'd0; bus.wr_data = 3'b101;
        cyc(0, 0); chk("preload0_ack", bus.wr_ack, 1); adv();
        bus.wr_addr = 15'd1; bus.wr_data = 3'b010;
        cyc(1, 0); chk("preload1_ack", bus.wr_ack, 1); adv();
        bus.wr_req = 1'b0;
        for (int x = 138; x <= 153; x++) begin
            int e;
            cyc(x, 35);
            e = (x >= 144 && x <= 147) ? 5 : (x >= 148 && x <= 151) ? 2 : 0;
            if (x >= 140) chk($sformatf("y35_rgb_x%0d", x), bus.rgb, e);
            if (x == 142) chk("read_x142", {bus.ram_en, bus.ram_we, bus.ram_addr}, {2'b10, 15'd0});
            if (x == 143) chk("noread_x143", bus.ram_en, 0);
            if (x == 146) chk("read_x146", {bus.ram_en, bus.ram_we, bus.ram_addr}, {2'b10, 15'd1});
            adv();
        end

        // Writer held across a display slot.
        bus.wr_req = 1'b1; bus.wr_addr = 15'd161; bus.wr_data = 3'b111;
        cyc(142, 39);
        chk("wr_noack_x142", {bus.wr_ack, bus.ram_en}, 2'b01);
        adv();
        cyc(143, 39);
`ifdef VGA_ARB_VBLANK_WR_EN
        chk("wr_noack_active_x143", {bus.wr_ack, bus.ram_we}, 0);
        adv();
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(k, 100); if (bus.wr_ack || bus.ram_we) bad++; adv();
            cyc(k, 300); if (bus.wr_ack || bus.ram_we) bad++; adv();
            cyc(k, 514); if (bus.wr_ack || bus.ram_we) bad++; adv();
        end
        chk("vblank_no_active_grant", bad, 0);
        cyc(10, 515);
        chk("vblank_ack_y515", {bus.wr_ack, bus.ram_we, bus.ram_addr}, {2'b11, 15'd161});
`else
        chk("wr_ack_x143", {bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata},
            {2'b11, 15'd161, 3'b111});
`endif
        adv();
        bus.wr_req = 1'b0;
        for (int y = 39; y <= 43; y++) row_check($sformatf("cell161_y%0d", y), 1, y, 140, 156);

        // Full clear in blanking with one display slot, a re-pulse and a waiting writer.
        bus.clr_start = 1'b1; bus.clr_color = 3'b011;
        cyc(0, 0); adv();
        bus.clr_start = 1'b0;
        bus.wr_req = 1'b1; bus.wr_addr = 15'd5; bus.wr_data = 3'd6;
        busy_cyc = 0; clr_wr = 0; early_ack = 0; done = 0;
        for (int i = 0; i < 20000 && done == 0; i++) begin
            bus.clr_start = (i == 100);
            bus.clr_color = (i == 100) ? 3'd5 : 3'd3;
            if (i == 200) cyc(142, 35); else cyc(0, 0);
            if (bus.clr_busy) begin
                busy_cyc++;
                if (bus.ram_en && bus.ram_we) clr_wr++;
                if (bus.wr_ack) early_ack++;
                if (i == 200) chk("slot_beats_clear", {bus.ram_en, bus.ram_we}, 2'b10);
            end else begin
                done = 1;
                chk("ack_after_clear", {bus.wr_ack, bus.ram_we, bus.ram_addr}, {2'b11, 15'd5});
            end
            adv();
        end
        bus.clr_start = 1'b0; bus.wr_req = 1'b0;
        chk("clear_done", done, 1);
        chk("clear_busy_cycles", busy_cyc, 19201);
        chk("clear_write_count", clr_wr, 19200);
        chk("no_ack_during_clear", early_ack, 0);
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (int'(mem[i]) != ((i == 5) ? 6 : 3)) bad++;
        chk("mem_fill", bad, 0);
        row_check("rgb_fill_y35", 2, 35, 140, 790);
        row_check("rgb_fill_y514", 2, 514, 140, 790);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
